// File: rtl/e_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : e_mdu_ctrl
//  Description : Execute-stage multiply/divide sequencer. Captures rs/rt on a
//                start pulse, holds the unit busy for a fixed number of
//                cycles, then commits the 64-bit result into HI/LO. Raises a
//                stall towards decode while an MDU instruction there would
//                collide with a busy (or just-starting) unit.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MULT_CYCLES : busy cycles for mult/multu (>=1, <=16)
//    DIV_CYCLES  : busy cycles for div/divu   (>=1, <=16)
//  Ports
//    clk     in   1   system clock, rising edge
//    reset   in   1   asynchronous active-high reset, clears all state
//    start   in   1   E-stage pulse, mdOp valid this cycle
//    mdOp    in   3   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 NONE
//    rs      in  32   operand A / dividend / mthi-mtlo source
//    rt      in  32   operand B / divisor
//    d_useMd in   1   decode-stage instruction uses the MDU or HI/LO
//    busy    out  1   countdown in progress
//    stall   out  1   freeze the D stage and bubble into E
//    hi      out 32   HI register
//    lo      out 32   LO register
// ============================================================================
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        d_useMd,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // --------------------------------------------------------------------------
  // Operation encodings
  // --------------------------------------------------------------------------
  localparam logic [2:0] C_OP_NONE  = 3'd0;
  localparam logic [2:0] C_OP_MULT  = 3'd1;
  localparam logic [2:0] C_OP_MULTU = 3'd2;
  localparam logic [2:0] C_OP_DIV   = 3'd3;
  localparam logic [2:0] C_OP_DIVU  = 3'd4;
  localparam logic [2:0] C_OP_MTHI  = 3'd5;
  localparam logic [2:0] C_OP_MTLO  = 3'd6;

  // The counter is loaded with N-1 so that, together with the commit edge,
  // busy stays high for exactly N cycles.
  localparam logic [3:0] C_MULT_CNT = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] C_DIV_CNT  = 4'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic        busy_q,  busy_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic [31:0] p_hi_q,  p_hi_d;   // pending HI, committed when the count expires
  logic [31:0] p_lo_q,  p_lo_d;   // pending LO
  logic        p_skip_q, p_skip_d; // pending result is a divide-by-zero: no commit

  // --------------------------------------------------------------------------
  // Operation decode
  // --------------------------------------------------------------------------
  logic w_op_is_mul;
  logic w_op_is_div;
  logic w_op_is_mdu;
  logic w_start_mdu;

  assign w_op_is_mul = (mdOp == C_OP_MULT) || (mdOp == C_OP_MULTU);
  assign w_op_is_div = (mdOp == C_OP_DIV)  || (mdOp == C_OP_DIVU);
  assign w_op_is_mdu = w_op_is_mul || w_op_is_div;
  assign w_start_mdu = start && w_op_is_mdu;

  // --------------------------------------------------------------------------
  // Multiplier: sign- or zero-extend both operands to 64 bits; the low 64
  // bits of the 64x64 product are the correct two's-complement result for
  // both the signed and the unsigned case.
  // --------------------------------------------------------------------------
  logic        w_mul_signed;
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_mul_prod;

  assign w_mul_signed = (mdOp == C_OP_MULT);
  assign w_mul_a      = {{32{w_mul_signed & rs[31]}}, rs};
  assign w_mul_b      = {{32{w_mul_signed & rt[31]}}, rt};
  assign w_mul_prod   = w_mul_a * w_mul_b;

  // --------------------------------------------------------------------------
  // Divider: done on magnitudes with an unsigned divide, signs reapplied
  // afterwards. This gives truncation toward zero with the remainder taking
  // the dividend's sign, and maps 0x80000000 / -1 to quotient 0x80000000,
  // remainder 0 without ever forming an overflowing signed divide.
  // A zero divisor is replaced by 1 so the datapath never divides by zero;
  // its result is discarded at commit anyway.
  // --------------------------------------------------------------------------
  logic        w_div_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_div_signed = (mdOp == C_OP_DIV);
  assign w_a_neg      = w_div_signed & rs[31];
  assign w_b_neg      = w_div_signed & rt[31];
  assign w_a_mag      = w_a_neg ? (~rs + 32'd1) : rs;
  assign w_b_mag      = w_b_neg ? (~rt + 32'd1) : rt;
  assign w_div_zero   = (rt == 32'd0);
  assign w_b_safe     = w_div_zero ? 32'd1 : w_b_mag;
  assign w_q_mag      = w_a_mag / w_b_safe;
  assign w_r_mag      = w_a_mag % w_b_safe;
  assign w_quot       = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem        = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    p_skip_d = p_skip_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          unique case (mdOp)
            C_OP_MULT, C_OP_MULTU: begin
              p_hi_d   = w_mul_prod[63:32];
              p_lo_d   = w_mul_prod[31:0];
              p_skip_d = 1'b0;
              cnt_d    = C_MULT_CNT;
              state_d  = ST_BUSY;
            end
            C_OP_DIV, C_OP_DIVU: begin
              p_hi_d   = w_rem;
              p_lo_d   = w_quot;
              p_skip_d = w_div_zero;
              cnt_d    = C_DIV_CNT;
              state_d  = ST_BUSY;
            end
            C_OP_MTHI: hi_d = rs;
            C_OP_MTLO: lo_d = rs;
            default: ;  // NONE and the reserved encoding do nothing
          endcase
        end
      end

      ST_BUSY: begin
        // A start arriving here is illegal (decode is stalled) and is
        // deliberately ignored: nothing in this branch looks at start.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!p_skip_q) begin
            hi_d = p_hi_q;
            lo_d = p_lo_q;
          end
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_BUSY);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      p_hi_q   <= 32'd0;
      p_lo_q   <= 32'd0;
      p_skip_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      p_skip_q <= p_skip_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. The stall includes the start cycle itself so a back-to-back
  // MDU instruction in decode is held from its first cycle; it falls in the
  // same cycle HI/LO are written, so a following mfhi/mflo sees new data.
  // --------------------------------------------------------------------------
  assign busy  = busy_q;
  assign stall = d_useMd && (busy_q || w_start_mdu);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_e_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_e_mdu_ctrl
//  Description : Directed self-checking bench for e_mdu_ctrl. Each vector
//                has hand-computed HI/LO values; busy and stall are checked
//                cycle by cycle across every operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_e_mdu_ctrl;

  localparam int C_MULT_N = 5;
  localparam int C_DIV_N  = 10;

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_MULT  = 3'd1;
  localparam logic [2:0] C_MULTU = 3'd2;
  localparam logic [2:0] C_DIV   = 3'd3;
  localparam logic [2:0] C_DIVU  = 3'd4;
  localparam logic [2:0] C_MTHI  = 3'd5;
  localparam logic [2:0] C_MTLO  = 3'd6;
  localparam logic [2:0] C_RSVD  = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mdOp = 3'd0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        d_useMd = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;

  e_mdu_ctrl #(
    .MULT_CYCLES (C_MULT_N),
    .DIV_CYCLES  (C_DIV_N)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mdOp    (mdOp),
    .rs      (rs),
    .rt      (rt),
    .d_useMd (d_useMd),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one MDU op with d_useMd held high and check busy/stall for every
  // cycle of the countdown; returns just after busy is expected to drop.
  task automatic run_mdu(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input int n);
    d_useMd = 1'b1;
    start   = 1'b1;
    mdOp    = op;
    rs      = a;
    rt      = b;
    #1;
    chk({tag, "_stall_start"}, 64'(stall), 64'd1);
    chk({tag, "_busy_start"},  64'(busy),  64'd0);
    step();
    start = 1'b0;
    mdOp  = C_NONE;
    for (int i = 1; i <= n; i++) begin
      chk($sformatf("%s_busy_c%0d", tag, i),  64'(busy),  64'd1);
      chk($sformatf("%s_stall_c%0d", tag, i), 64'(stall), 64'd1);
      step();
    end
    chk({tag, "_busy_end"},  64'(busy),  64'd0);
    chk({tag, "_stall_end"}, 64'(stall), 64'd0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (2) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    d_useMd = 1'b1;
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // ---------------- 1: MULT 3 * -2 ----------------
    run_mdu("mult", C_MULT, 32'h0000_0003, 32'hFFFF_FFFE, C_MULT_N);
    chk("mult_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'h0000_0000_FFFF_FFFA);

    // ---------------- 2: MULTU 0xFFFFFFFF * 2 ----------------
    run_mdu("multu", C_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, C_MULT_N);
    chk("multu_hi", 64'(hi), 64'h0000_0001);
    chk("multu_lo", 64'(lo), 64'hFFFF_FFFE);

    // ---------------- 3: DIV -7 / 2, then DIVU 7 / 0 ----------------
    run_mdu("div", C_DIV, 32'hFFFF_FFF9, 32'h0000_0002, C_DIV_N);
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
    run_mdu("divu0", C_DIVU, 32'h0000_0007, 32'h0000_0000, C_DIV_N);
    chk("divu0_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("divu0_hi", 64'(hi), 64'hFFFF_FFFF);

    // DIV 7 / -2 : q=-3, r=+1 (remainder follows dividend)
    run_mdu("div_nd", C_DIV, 32'h0000_0007, 32'hFFFF_FFFE, C_DIV_N);
    chk("div_nd_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_nd_hi", 64'(hi), 64'h0000_0001);
    // Overflow corner
    run_mdu("div_ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, C_DIV_N);
    chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(hi), 64'h0000_0000);
    // DIVU treats the top bit as magnitude: 0x80000000 / 3
    run_mdu("divu", C_DIVU, 32'h8000_0000, 32'h0000_0003, C_DIV_N);
    chk("divu_lo", 64'(lo), 64'h2AAA_AAAA);
    chk("divu_hi", 64'(hi), 64'h0000_0002);

    // ---------------- 4: MTHI / MTLO, no-ops ----------------
    d_useMd = 1'b1;
    start   = 1'b1;
    mdOp    = C_MTHI;
    rs      = 32'h0000_1234;
    #1;
    chk("mthi_stall", 64'(stall), 64'd0);
    step();
    start = 1'b0;
    mdOp  = C_NONE;
    chk("mthi_hi",   64'(hi),   64'h0000_1234);
    chk("mthi_lo",   64'(lo),   64'h2AAA_AAAA);
    chk("mthi_busy", 64'(busy), 64'd0);

    start = 1'b1;
    mdOp  = C_MTLO;
    rs    = 32'h0000_5678;
    step();
    start = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h0000_5678);
    chk("mtlo_hi", 64'(hi), 64'h0000_1234);

    start = 1'b1;
    mdOp  = C_RSVD;
    rs    = 32'hDEAD_BEEF;
    rt    = 32'h0000_0001;
    step();
    mdOp  = C_NONE;
    step();
    start = 1'b0;
    chk("nop_hi",   64'(hi),   64'h0000_1234);
    chk("nop_lo",   64'(lo),   64'h0000_5678);
    chk("nop_busy", 64'(busy), 64'd0);

    // stall only when decode actually uses the MDU
    d_useMd = 1'b0;
    start   = 1'b1;
    mdOp    = C_MULT;
    rs      = 32'd2;
    rt      = 32'd3;
    #1;
    chk("nouse_stall_start", 64'(stall), 64'd0);
    step();
    start = 1'b0;
    mdOp  = C_NONE;
    chk("nouse_stall_busy", 64'(stall), 64'd0);
    chk("nouse_busy",       64'(busy),  64'd1);
    repeat (C_MULT_N) step();
    chk("nouse_hi", 64'(hi), 64'd0);
    chk("nouse_lo", 64'(lo), 64'd6);

    // ---------------- 5: reset mid-divide ----------------
    d_useMd = 1'b1;
    start   = 1'b1;
    mdOp    = C_DIV;
    rs      = 32'd100;
    rt      = 32'd7;
    step();                 // E0: busy cycle 1 begins
    start = 1'b0;
    mdOp  = C_NONE;
    repeat (3) step();      // now in busy cycle 4
    chk("rst_mid_busy_pre", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hi",   64'(hi),   64'd0);
    chk("rst_mid_lo",   64'(lo),   64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (C_DIV_N + 2) step();
    chk("rst_mid_late_hi",   64'(hi),   64'd0);
    chk("rst_mid_late_lo",   64'(lo),   64'd0);
    chk("rst_mid_late_busy", 64'(busy), 64'd0);

    // ---------------- 5b: start while busy is ignored ----------------
    start = 1'b1;
    mdOp  = C_DIVU;
    rs    = 32'd100;
    rt    = 32'd7;
    step();                 // E0
    start = 1'b0;
    mdOp  = C_NONE;
    chk("ign_busy_c1", 64'(busy), 64'd1);
    step();                 // busy cycle 2: force an illegal start
    start = 1'b1;
    mdOp  = C_MULT;
    rs    = 32'd5;
    rt    = 32'd5;
    chk("ign_busy_c2", 64'(busy), 64'd1);
    step();
    start = 1'b0;
    mdOp  = C_NONE;
    for (int i = 3; i <= C_DIV_N; i++) begin
      chk($sformatf("ign_busy_c%0d", i), 64'(busy), 64'd1);
      step();
    end
    chk("ign_busy_end", 64'(busy), 64'd0);
    chk("ign_hi",       64'(hi),   64'd2);
    chk("ign_lo",       64'(lo),   64'd14);
    repeat (C_MULT_N + 2) step();
    chk("ign_hi_later", 64'(hi), 64'd2);
    chk("ign_lo_later", 64'(lo), 64'd14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
